// File: rtl/eth_status_pkg.sv
// Shared constants and types for the Ethernet status poller and its reply parsers.
// Request words carry "GET" in the top bits, then the channel number, then zero padding.
package eth_status_pkg;

  localparam logic [23:0] ASCII_GET = 24'h474554;
  localparam logic [15:0] ASCII_ON  = 16'h4F4E;
  localparam logic [23:0] ASCII_OFF = 24'h4F4646;

  localparam int REQ_CMD_W = 24;
  localparam int REQ_CH_W  = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

  // A counter that only ever holds 0 still needs one bit.
  function automatic int cnt_w(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/eth_resp_decode.sv
// Classifies a right-justified ASCII reply word as ON, OFF or malformed.
// The whole word is compared, so any stray upper bits make a reply malformed.
module eth_resp_decode
  import eth_status_pkg::*;
#(
  parameter int DATA_W = 48
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              is_on_o,
  output logic              is_off_o,
  output logic              malformed_o
);

  assign is_on_o     = (data_i == {{(DATA_W-16){1'b0}}, ASCII_ON});
  assign is_off_o    = (data_i == {{(DATA_W-24){1'b0}}, ASCII_OFF});
  assign malformed_o = ~(is_on_o | is_off_o);

endmodule

// File: rtl/eth_status_poller.sv
// Periodically sends a GET request to each channel, waits for an ON/OFF reply,
// and records per-channel status, retrying on timeouts and flagging exhausted channels.
module eth_status_poller
  import eth_status_pkg::*;
#(
  parameter int DATA_W      = 48,
  parameter int NUM_CH      = 4,
  parameter int POLL_PERIOD = 100,
  parameter int TIMEOUT     = 64,
  parameter int MAX_RETRY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] eth_rx_data,
  input  logic              eth_rx_valid,
  output logic              eth_rx_ready,
  output logic [DATA_W-1:0] eth_tx_data,
  output logic              eth_tx_valid,
  input  logic              eth_tx_ready,
  output logic [NUM_CH-1:0] status,
  output logic [NUM_CH-1:0] err,
  output logic              status_valid
);

  localparam int PW = cnt_w(POLL_PERIOD);
  localparam int TW = cnt_w(TIMEOUT);
  localparam int RW = cnt_w(MAX_RETRY + 1);
  localparam int CW = cnt_w(NUM_CH);

  state_t            state_q, state_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic              sv_q, sv_d;

  logic is_on, is_off, malformed;
  logic good, fail, ch_done;

  eth_resp_decode #(.DATA_W(DATA_W)) u_decode (
    .data_i      (eth_rx_data),
    .is_on_o     (is_on),
    .is_off_o    (is_off),
    .malformed_o (malformed)
  );

  // A valid reply on the terminal timeout cycle takes priority over the timeout.
  assign good = (state_q == ST_WAIT) & eth_rx_valid & (is_on | is_off);
  assign fail = (state_q == ST_WAIT) &
                ((eth_rx_valid & malformed) |
                 (~eth_rx_valid & (tcnt_q == TW'(TIMEOUT - 1))));

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latch).
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    tcnt_d   = tcnt_q;
    retry_d  = retry_q;
    ch_d     = ch_q;
    status_d = status_q;
    err_d    = err_q;
    sv_d     = 1'b0;
    ch_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          pcnt_d = '0;
        end else if (pcnt_q == PW'(POLL_PERIOD - 1)) begin
          pcnt_d  = '0;
          ch_d    = '0;
          retry_d = '0;
          state_d = ST_SEND;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (eth_tx_ready) begin
          tcnt_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (good) begin
          status_d[ch_q] = is_on;
          err_d[ch_q]    = 1'b0;
          ch_done        = 1'b1;
        end else if (fail) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_SEND;
          end else begin
            err_d[ch_q] = 1'b1;
            ch_done     = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ch_done) begin
      if (ch_q != CW'(NUM_CH - 1)) begin
        ch_d    = ch_q + 1'b1;
        retry_d = '0;
        state_d = ST_SEND;
      end else begin
        sv_d    = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pcnt_q   <= '0;
      tcnt_q   <= '0;
      retry_q  <= '0;
      ch_q     <= '0;
      status_q <= '0;
      err_q    <= '0;
      sv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      tcnt_q   <= tcnt_d;
      retry_q  <= retry_d;
      ch_q     <= ch_d;
      status_q <= status_d;
      err_q    <= err_d;
      sv_q     <= sv_d;
    end
  end

  // Request data is decoded from registered state, so it holds steady through any stall.
  assign eth_tx_valid = (state_q == ST_SEND);
  assign eth_tx_data  = eth_tx_valid ?
                        {ASCII_GET, REQ_CH_W'(ch_q), {(DATA_W-REQ_CMD_W-REQ_CH_W){1'b0}}} :
                        '0;
  assign eth_rx_ready = (state_q == ST_WAIT);
  assign status       = status_q;
  assign err          = err_q;
  assign status_valid = sv_q;

endmodule

// File: tb/tb_eth_status_poller.sv
// Self-checking bench for eth_status_poller with NUM_CH=2, POLL_PERIOD=10, TIMEOUT=8, MAX_RETRY=1.
// Per-attempt vectors drive replies and check results; hand sequences cover reset, enable and stalls.
module tb_eth_status_poller;

  localparam int DATA_W      = 48;
  localparam int NUM_CH      = 2;
  localparam int POLL_PERIOD = 10;
  localparam int TIMEOUT     = 8;
  localparam int MAX_RETRY   = 1;
  localparam int NVEC        = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [DATA_W-1:0] eth_rx_data;
  logic              eth_rx_valid;
  logic              eth_rx_ready;
  logic [DATA_W-1:0] eth_tx_data;
  logic              eth_tx_valid;
  logic              eth_tx_ready;
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] err;
  logic              status_valid;

  eth_status_poller #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .POLL_PERIOD(POLL_PERIOD),
    .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .eth_rx_data  (eth_rx_data),
    .eth_rx_valid (eth_rx_valid),
    .eth_rx_ready (eth_rx_ready),
    .eth_tx_data  (eth_tx_data),
    .eth_tx_valid (eth_tx_valid),
    .eth_tx_ready (eth_tx_ready),
    .status       (status),
    .err          (err),
    .status_valid (status_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    bit          reply;
    logic [47:0] data;
    int          delay;
    logic [1:0]  exp_status;
    logic [1:0]  exp_err;
    bit          exp_sv;
  } vec_t;

  vec_t vecs [NVEC];
  int   tests_run = 0;
  int   tests_failed = 0;

  localparam logic [47:0] R_ON  = 48'h4F4E;
  localparam logic [47:0] R_OFF = 48'h4F4646;
  localparam logic [47:0] R_BAD = 48'h4F4F;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] exp_req(input int ch);
    logic [7:0] c;
    c = 8'(ch);
    return {24'h474554, c, 16'h0000};
  endfunction

  function automatic vec_t mk(input int ch, input bit reply, input logic [47:0] data,
                              input int delay, input logic [1:0] st, input logic [1:0] er,
                              input bit sv);
    vec_t v;
    v.ch = ch; v.reply = reply; v.data = data; v.delay = delay;
    v.exp_status = st; v.exp_err = er; v.exp_sv = sv;
    return v;
  endfunction

  // Each vector is one request attempt: a reply after `delay` WAIT cycles, or silence until timeout.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      int n;
      int sv_seen;
      int bad;
      n = 0;
      sv_seen = 0;
      while (!eth_tx_valid && n < 40) begin
        step();
        n++;
        if (status_valid) sv_seen++;
      end
      check($sformatf("v%0d tx_valid", i), 64'(eth_tx_valid), 64'(1));
      check($sformatf("v%0d tx_data", i), 64'(eth_tx_data), 64'(exp_req(vecs[i].ch)));
      check($sformatf("v%0d extra status_valid", i), 64'(sv_seen), 64'(0));
      step();
      check($sformatf("v%0d after handshake tx_valid,rx_ready", i),
            64'({eth_tx_valid, eth_rx_ready}), 64'(2'b01));
      if (vecs[i].reply) begin
        repeat (vecs[i].delay - 1) step();
        eth_rx_valid = 1'b1;
        eth_rx_data  = vecs[i].data;
        step();
        eth_rx_valid = 1'b0;
        eth_rx_data  = '0;
      end else begin
        bad = 0;
        for (int k = 0; k < TIMEOUT - 1; k++) begin
          step();
          if (!eth_rx_ready) bad++;
        end
        step();
        check($sformatf("v%0d rx_ready held through timeout", i), 64'(bad), 64'(0));
      end
      check($sformatf("v%0d status", i), 64'(status), 64'(vecs[i].exp_status));
      check($sformatf("v%0d err", i), 64'(err), 64'(vecs[i].exp_err));
      check($sformatf("v%0d sv,tx_valid,rx_ready", i),
            64'({status_valid, eth_tx_valid, eth_rx_ready}),
            64'(vecs[i].exp_sv ? 3'b100 : 3'b010));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int sv_cnt;
    int bad;

    // Sweep 1: basic ON/OFF.
    vecs[0]  = mk(0, 1, R_ON,  3, 2'b01, 2'b00, 0);
    vecs[1]  = mk(1, 1, R_OFF, 3, 2'b01, 2'b00, 1);
    // Sweep 2: ch0 timeout then recovery; ch1 replies on the terminal timeout cycle.
    vecs[2]  = mk(0, 0, '0,    0, 2'b01, 2'b00, 0);
    vecs[3]  = mk(0, 1, R_ON,  2, 2'b01, 2'b00, 0);
    vecs[4]  = mk(1, 1, R_ON,  8, 2'b11, 2'b00, 1);
    // Sweep 3: malformed reply retried; ch1 exhausts its retries and keeps status.
    vecs[5]  = mk(0, 1, R_BAD, 1, 2'b11, 2'b00, 0);
    vecs[6]  = mk(0, 1, R_OFF, 1, 2'b10, 2'b00, 0);
    vecs[7]  = mk(1, 0, '0,    0, 2'b10, 2'b00, 0);
    vecs[8]  = mk(1, 0, '0,    0, 2'b10, 2'b10, 1);
    // Sweep 4: good replies clear the error.
    vecs[9]  = mk(0, 1, R_ON,  4, 2'b11, 2'b10, 0);
    vecs[10] = mk(1, 1, R_OFF, 5, 2'b01, 2'b00, 1);

    rst_n        = 1'b0;
    enable       = 1'b0;
    eth_rx_data  = '0;
    eth_rx_valid = 1'b0;
    eth_tx_ready = 1'b0;
    #1;
    check("reset outputs", 64'({eth_tx_valid, eth_rx_ready, status, err, status_valid}), 64'(0));
    check("reset tx_data", 64'(eth_tx_data), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Disabled: no requests, and a reply pulse in IDLE is ignored.
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      if (k == 10) begin
        eth_rx_valid = 1'b1;
        eth_rx_data  = R_ON;
        check("rx_ready low in IDLE", 64'(eth_rx_ready), 64'(0));
      end
      step();
      eth_rx_valid = 1'b0;
      eth_rx_data  = '0;
      if (eth_tx_valid) cnt++;
    end
    check("no tx while disabled", 64'(cnt), 64'(0));
    check("IDLE reply not accepted", 64'({status, err}), 64'(0));

    // Period latency: request appears POLL_PERIOD cycles after enable rises.
    enable = 1'b1;
    repeat (POLL_PERIOD - 1) step();
    check("tx_valid not yet", 64'(eth_tx_valid), 64'(0));
    step();
    check("tx_valid after period", 64'(eth_tx_valid), 64'(1));

    // Backpressure: request held stable while the MAC stalls.
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (!eth_tx_valid || eth_tx_data !== exp_req(0)) bad++;
    end
    check("tx held during stall", 64'(bad), 64'(0));
    eth_tx_ready = 1'b1;

    run_vecs(0, NVEC);

    // Asynchronous reset in the middle of WAIT.
    cnt = 0;
    while (!eth_tx_valid && cnt < 40) begin
      step();
      cnt++;
    end
    check("tx before reset test", 64'(eth_tx_valid), 64'(1));
    step();
    step();
    check("in WAIT before reset", 64'(eth_rx_ready), 64'(1));
    #2 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("async reset outputs", 64'({eth_tx_valid, eth_rx_ready, status, err, status_valid}), 64'(0));
    check("async reset tx_data", 64'(eth_tx_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    sv_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (eth_tx_valid) cnt++;
      if (status_valid) sv_cnt++;
    end
    check("no tx after reset with enable=0", 64'(cnt), 64'(0));
    check("no status_valid after reset", 64'(sv_cnt), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
